// File: rtl/wb_dram_bist_pkg.sv
// Shared types and constants for the Wishbone DRAM built-in self-test.
package wb_dram_bist_pkg;

   typedef enum logic [1:0] {
      ModeConst   = 2'd0,
      ModeAddrXor = 2'd1,
      ModeLfsr    = 2'd2,
      ModeWalk    = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StWrGap,
      StRd,
      StRdGap,
      StFin
   } state_e;

   localparam logic [63:0] Poly32 = 64'h0000_0000_8020_0003;
   localparam logic [63:0] Poly64 = 64'hD800_0000_0000_0000;

   // Other widths fall back to a simple top+bottom tap pair.
   function automatic logic [63:0] lfsr_poly(input int unsigned width);
      if (width == 32) begin
         return Poly32;
      end else if (width == 64) begin
         return Poly64;
      end
      return (64'd1 << (width - 1)) | 64'd1;
   endfunction

endpackage

// File: rtl/wb_dram_bist_patgen.sv
// Pattern generator: yields the data word and word address for the current index.
module wb_dram_bist_patgen
   import wb_dram_bist_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 30,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic                  advance_i,
   input  logic [1:0]            mode_i,
   input  logic [DATA_WIDTH-1:0] seed_i,
   input  logic [ADDR_WIDTH-1:0] base_i,
   output logic [DATA_WIDTH-1:0] pattern_o,
   output logic [ADDR_WIDTH-1:0] addr_o
);

   localparam logic [DATA_WIDTH-1:0] Poly = DATA_WIDTH'(lfsr_poly(DATA_WIDTH));

   logic [1:0]            mode_q;
   logic [DATA_WIDTH-1:0] seed_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] lfsr_q;
   logic [DATA_WIDTH-1:0] lfsr_d;
   logic [DATA_WIDTH-1:0] onehot_q;

   always_comb begin
      lfsr_d = lfsr_q >> 1;
      if (lfsr_q[0]) begin
         lfsr_d = lfsr_d ^ Poly;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q   <= '0;
         seed_q   <= '0;
         addr_q   <= '0;
         lfsr_q   <= '0;
         onehot_q <= '0;
      end else if (load_i) begin
         mode_q   <= mode_i;
         seed_q   <= seed_i;
         addr_q   <= base_i;
         // An all-zero LFSR would lock up.
         lfsr_q   <= (seed_i == '0) ? DATA_WIDTH'(1) : seed_i;
         onehot_q <= DATA_WIDTH'(1);
      end else if (advance_i) begin
         addr_q   <= addr_q + ADDR_WIDTH'(1);
         lfsr_q   <= lfsr_d;
         onehot_q <= {onehot_q[DATA_WIDTH-2:0], onehot_q[DATA_WIDTH-1]};
      end
   end

   always_comb begin
      pattern_o = seed_q;
      case (mode_e'(mode_q))
         ModeConst:   pattern_o = seed_q;
         ModeAddrXor: pattern_o = seed_q ^ DATA_WIDTH'(addr_q);
         ModeLfsr:    pattern_o = lfsr_q;
         ModeWalk:    pattern_o = onehot_q;
         default:     pattern_o = seed_q;
      endcase
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/wb_dram_bist.sv
// Wishbone master that writes a generated pattern over a DRAM region, then reads it back
// and checks it, reporting error count, first failure, bus timeout and busy-cycle count.
module wb_dram_bist
   import wb_dram_bist_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 30,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned ERR_WIDTH  = 16,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [1:0]              mode_i,
   input  logic [ADDR_WIDTH-1:0]   base_i,
   input  logic [LEN_WIDTH-1:0]    length_i,
   input  logic [DATA_WIDTH-1:0]   seed_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    pass_o,
   output logic                    timeout_o,
   output logic [ERR_WIDTH-1:0]    err_count_o,
   output logic [ADDR_WIDTH-1:0]   first_err_addr_o,
   output logic [DATA_WIDTH-1:0]   first_err_data_o,
   output logic [31:0]             cycles_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_w_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_r_i,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i
);

   localparam int unsigned WaitW = $clog2(TIMEOUT);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

   state_e                state_q;
   logic                  busy_q, done_q, pass_q, timeout_q;
   logic                  cyc_q, stb_q, we_q;
   logic [ERR_WIDTH-1:0]  err_q;
   logic                  err_seen_q;
   logic [ADDR_WIDTH-1:0] ferr_addr_q;
   logic [DATA_WIDTH-1:0] ferr_data_q;
   logic [31:0]           cycles_q;
   logic [WaitW-1:0]      wait_q;
   logic [LEN_WIDTH-1:0]  idx_q, len_q;
   logic [1:0]            mode_q;
   logic [DATA_WIDTH-1:0] seed_q;
   logic [ADDR_WIDTH-1:0] base_q;

   logic                  accept, xfer_end, last_word, rd_mismatch;
   logic                  pg_load, pg_advance;
   logic [1:0]            pg_mode;
   logic [DATA_WIDTH-1:0] pg_seed, pattern;
   logic [ADDR_WIDTH-1:0] pg_base, pg_addr;
   logic [ERR_WIDTH-1:0]  err_inc;

   assign accept      = (state_q == StIdle) && start_i;
   assign xfer_end    = stb_q && (wb_ack_i || wb_err_i);
   assign last_word   = ({1'b0, idx_q} + (LEN_WIDTH + 1)'(1)) >= {1'b0, len_q};
   assign rd_mismatch = wb_dat_r_i != pattern;
   assign err_inc     = (err_q == '1) ? err_q : err_q + ERR_WIDTH'(1);

   // The generator loads straight from the ports at start, and from the latched copies when
   // it is rewound for the read pass.
   assign pg_mode    = (state_q == StIdle) ? mode_i : mode_q;
   assign pg_seed    = (state_q == StIdle) ? seed_i : seed_q;
   assign pg_base    = (state_q == StIdle) ? base_i : base_q;
   assign pg_load    = (accept && (length_i != '0)) || ((state_q == StWrGap) && last_word);
   assign pg_advance = ((state_q == StWr) || (state_q == StRd)) && xfer_end;

   wb_dram_bist_patgen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_patgen (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_i    (pg_load),
      .advance_i (pg_advance),
      .mode_i    (pg_mode),
      .seed_i    (pg_seed),
      .base_i    (pg_base),
      .pattern_o (pattern),
      .addr_o    (pg_addr)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         err_q       <= '0;
         err_seen_q  <= 1'b0;
         ferr_addr_q <= '0;
         ferr_data_q <= '0;
         cycles_q    <= '0;
         wait_q      <= '0;
         idx_q       <= '0;
         len_q       <= '0;
         mode_q      <= '0;
         seed_q      <= '0;
         base_q      <= '0;
      end else begin
         done_q <= 1'b0;
         if (busy_q && (cycles_q != '1)) begin
            cycles_q <= cycles_q + 32'd1;
         end
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  err_q       <= '0;
                  err_seen_q  <= 1'b0;
                  ferr_addr_q <= '0;
                  ferr_data_q <= '0;
                  timeout_q   <= 1'b0;
                  cycles_q    <= '0;
                  wait_q      <= '0;
                  idx_q       <= '0;
                  if (length_i == '0) begin
                     done_q  <= 1'b1;
                     pass_q  <= 1'b1;
                     state_q <= StFin;
                  end else begin
                     pass_q  <= 1'b0;
                     len_q   <= length_i;
                     mode_q  <= mode_i;
                     seed_q  <= seed_i;
                     base_q  <= base_i;
                     busy_q  <= 1'b1;
                     cyc_q   <= 1'b1;
                     stb_q   <= 1'b1;
                     we_q    <= 1'b1;
                     state_q <= StWr;
                  end
               end
            end
            StWr, StRd: begin
               // A response in the expiry cycle still completes the transfer.
               if (xfer_end) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  wait_q  <= '0;
                  state_q <= (state_q == StWr) ? StWrGap : StRdGap;
                  if (wb_err_i) begin
                     err_q <= err_inc;
                     if ((state_q == StRd) && !err_seen_q) begin
                        err_seen_q  <= 1'b1;
                        ferr_addr_q <= pg_addr;
                        ferr_data_q <= '0;
                     end
                  end else if ((state_q == StRd) && rd_mismatch) begin
                     err_q <= err_inc;
                     if (!err_seen_q) begin
                        err_seen_q  <= 1'b1;
                        ferr_addr_q <= pg_addr;
                        ferr_data_q <= wb_dat_r_i;
                     end
                  end
               end else if (wait_q == WaitLast) begin
                  cyc_q     <= 1'b0;
                  stb_q     <= 1'b0;
                  timeout_q <= 1'b1;
                  pass_q    <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= StFin;
               end else begin
                  wait_q <= wait_q + WaitW'(1);
               end
            end
            StWrGap, StRdGap: begin
               if (!last_word) begin
                  idx_q   <= idx_q + LEN_WIDTH'(1);
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  state_q <= (state_q == StWrGap) ? StWr : StRd;
               end else if (state_q == StWrGap) begin
                  idx_q   <= '0;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  we_q    <= 1'b0;
                  state_q <= StRd;
               end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_q == '0);
                  state_q <= StFin;
               end
            end
            StFin: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign pass_o           = pass_q;
   assign timeout_o        = timeout_q;
   assign err_count_o      = err_q;
   assign first_err_addr_o = ferr_addr_q;
   assign first_err_data_o = ferr_data_q;
   assign cycles_o         = cycles_q;
   assign wb_cyc_o         = cyc_q;
   assign wb_stb_o         = stb_q;
   assign wb_we_o          = we_q;
   assign wb_adr_o         = stb_q ? pg_addr : '0;
   assign wb_dat_w_o       = (stb_q && we_q) ? pattern : '0;
   assign wb_sel_o         = stb_q ? '1 : '0;

endmodule
